multicycle_ctrl: RTL

Moore-style FSM plus ALU decode that sequences the shared-ALU, shared-memory multicycle MIPS datapath. It drives the datapath through fetch, decode, execute, memory and writeback steps for lw, sw, R-type (add/sub/and/or/slt), beq, addi and j. It stalls on memory wait states through a ready handshake, and emits a retire pulse and an illegal-instruction pulse for debug and verification.

---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       retire;
  logic       illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output iord, irwrite, pcen, memwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, state, retire, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, irwrite, pcen, memwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, state, retire, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore FSM plus ALU decode sequencing a shared-ALU, shared-memory multicycle
// MIPS datapath (lw, sw, R-type, beq, addi, j) with memory wait-state stalls.
module multicycle_ctrl #(
  parameter int MEM_WAIT = 1
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.master bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_EXECUTE = 4'd6, S_ALUWB  = 4'd7,
    S_BRANCH  = 4'd8,  S_ADDIEX  = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_t;

  state_t     state_reg, state_next, cur;
  logic       is_lw_reg;
  logic       ready;
  logic       funct_ok;
  logic [2:0] funct_alu;
  logic       op_ok;

  logic irwrite_c, pcwrite_c, branch_c, memwrite_c, regwrite_c, retire_c, illegal_c;

  assign ready = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = 3'b010;
    case (bus.funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    op_ok = 1'b0;
    case (bus.op)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
      OP_RTYPE:                             op_ok = funct_ok;
      default:                              op_ok = 1'b0;
    endcase
  end

  // lw/sw choice is latched in DECODE so op is not consulted again in MEMADR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
      is_lw_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE)
        is_lw_reg <= (bus.op == OP_LW);
    end
  end

  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:   state_next = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = funct_ok ? S_EXECUTE : S_FETCH;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:  state_next = is_lw_reg ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_next = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_next = ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_ADDIWB;
      default:   state_next = S_FETCH;
    endcase
  end

  // During reset the outputs show FETCH values; enables are gated off below.
  always_comb begin
    cur            = reset ? S_FETCH : state_reg;
    bus.iord       = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.alucontrol = 3'b010;
    irwrite_c      = 1'b0;
    pcwrite_c      = 1'b0;
    branch_c       = 1'b0;
    memwrite_c     = 1'b0;
    regwrite_c     = 1'b0;
    retire_c       = 1'b0;
    illegal_c      = 1'b0;
    case (cur)
      S_FETCH: begin
        bus.alusrcb = 2'b01;
        irwrite_c   = ready;
        pcwrite_c   = ready;
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        illegal_c   = ~op_ok;
      end
      S_MEMADR, S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD: bus.iord = 1'b1;
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite_c   = 1'b1;
        retire_c     = 1'b1;
      end
      S_MEMWR: begin
        bus.iord   = 1'b1;
        memwrite_c = 1'b1;
        retire_c   = ready;
      end
      S_EXECUTE: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = funct_alu;
      end
      S_ALUWB: begin
        bus.regdst = 1'b1;
        regwrite_c = 1'b1;
        retire_c   = 1'b1;
      end
      S_ADDIWB: begin
        regwrite_c = 1'b1;
        retire_c   = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = 3'b110;
        bus.pcsrc      = 2'b01;
        branch_c       = 1'b1;
        retire_c       = 1'b1;
      end
      S_JUMP: begin
        bus.pcsrc = 2'b10;
        pcwrite_c = 1'b1;
        retire_c  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state    = cur;
  assign bus.irwrite  = irwrite_c & ~reset;
  assign bus.pcen     = (pcwrite_c | (branch_c & bus.zero)) & ~reset;
  assign bus.memwrite = memwrite_c & ~reset;
  assign bus.regwrite = regwrite_c & ~reset;
  assign bus.retire   = retire_c & ~reset;
  assign bus.illegal  = illegal_c & ~reset;
endmodule
